// File: rtl/qspi_pkg.sv
// Shared types and opcodes for the QSPI execute-in-place read engine.
package qspi_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StCmd,
      StAddr,
      StMode,
      StDummy,
      StData,
      StCsHold
   } xip_state_e;

   localparam logic [7:0] CmdQuadIoRead = 8'hEB;
   localparam logic [7:0] ModeContRead  = 8'hA0;

endpackage

// File: rtl/qspi_sck_gen.sv
// SPI mode-0 clock divider; strobes mark the h_clk cycle that drives SCK high or low.
module qspi_sck_gen #(
   parameter int unsigned SckHalf = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic run_i,
   input  logic stall_i,
   output logic sck_o,
   output logic rise_stb_o,
   output logic fall_stb_o
);

   logic [3:0] div_q, div_d;
   logic       sck_q, sck_d;
   logic       adv;
   logic       toggle;

   always_comb begin
      // A stall only freezes the low phase so a started high phase always completes.
      adv        = run_i && !(stall_i && !sck_q);
      toggle     = adv && (div_q == 4'(SckHalf - 1));
      rise_stb_o = toggle && !sck_q;
      fall_stb_o = toggle && sck_q;
      div_d      = div_q;
      sck_d      = sck_q;
      if (!run_i) begin
         div_d = '0;
         sck_d = 1'b0;
      end else if (toggle) begin
         div_d = '0;
         sck_d = !sck_q;
      end else if (adv) begin
         div_d = div_q + 4'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         div_q <= '0;
         sck_q <= 1'b0;
      end else begin
         div_q <= div_d;
         sck_q <= sck_d;
      end
   end

   assign sck_o = sck_q;

endmodule

// File: rtl/qspi_xip_read_engine.sv
// Quad-IO fast read (0xEB) engine: streams flash data into a read FIFO until told to break.
module qspi_xip_read_engine
   import qspi_pkg::*;
#(
   parameter int unsigned SCK_HALF    = 2,
   parameter int unsigned CS_HIGH_CYC = 4,
   parameter int unsigned DUMMY_CYC   = 4
) (
   input  logic        h_clk,
   input  logic        h_rstn,
   input  logic        start_new_xip_seq_in,
   input  logic        break_seq_in,
   input  logic [23:0] xip_addr_in,
   output logic        qspi_busy_out,
   input  logic        rd_fifo_full_in,
   output logic        rd_fifo_wr_en_out,
   output logic [31:0] rd_fifo_wdata_out,
   output logic        qspi_sck_out,
   output logic        qspi_cs_n_out,
   output logic [3:0]  qspi_io_out,
   output logic [3:0]  qspi_io_oe_out,
   input  logic [3:0]  qspi_io_in
);

   xip_state_e  state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] sr_q, sr_d;
   logic [31:0] data_q, data_d;
   logic        pending_q, pending_d;
   logic        run, push, brk_take;
   logic        sck, rise_stb, fall_stb;

   qspi_sck_gen #(
      .SckHalf(SCK_HALF)
   ) u_sck_gen (
      .clk_i     (h_clk),
      .rst_ni    (h_rstn),
      .run_i     (run),
      .stall_i   (pending_q),
      .sck_o     (sck),
      .rise_stb_o(rise_stb),
      .fall_stb_o(fall_stb)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sr_d      = sr_q;
      data_d    = data_q;
      pending_d = pending_q;
      run       = state_q inside {StCmd, StAddr, StMode, StDummy, StData};
      push      = pending_q && !rd_fifo_full_in && (state_q == StData);
      // Never leave while SCK is high or about to go high.
      brk_take  = break_seq_in && ((!sck && !rise_stb) || fall_stb);

      unique case (state_q)
         StIdle: begin
            if (start_new_xip_seq_in) begin
               state_d = StCmd;
               // Address rides behind the opcode and reaches the top after 8 single-bit shifts.
               sr_d    = {CmdQuadIoRead, xip_addr_in};
               cnt_d   = '0;
               data_d  = '0;
            end
         end
         StCmd, StAddr, StMode, StDummy: begin
            if (rise_stb) cnt_d = cnt_q + 8'd1;
            if (fall_stb) begin
               sr_d = (state_q == StCmd) ? {sr_q[30:0], 1'b0} : {sr_q[27:0], 4'h0};
               unique case (state_q)
                  StCmd: if (cnt_q == 8'd8) begin
                     state_d = StAddr;
                     cnt_d   = '0;
                  end
                  StAddr: if (cnt_q == 8'd6) begin
                     state_d = StMode;
                     cnt_d   = '0;
                     sr_d    = {ModeContRead, 24'h0};
                  end
                  StMode: if (cnt_q == 8'd2) begin
                     state_d = StDummy;
                     cnt_d   = '0;
                  end
                  default: if (cnt_q == 8'(DUMMY_CYC)) begin
                     state_d = StData;
                     cnt_d   = '0;
                  end
               endcase
            end
         end
         StData: begin
            if (rise_stb) begin
               data_d[{cnt_q[2:1], ~cnt_q[0], 2'b00} +: 4] = qspi_io_in;
               cnt_d = {5'd0, cnt_q[2:0] + 3'd1};
               if (cnt_q[2:0] == 3'd7) pending_d = 1'b1;
            end
            if (push) pending_d = 1'b0;
         end
         StCsHold: begin
            if (cnt_q == 8'(CS_HIGH_CYC - 1)) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = StIdle;
      endcase

      if (run && brk_take) begin
         state_d   = StCsHold;
         cnt_d     = '0;
         pending_d = 1'b0;
      end
   end

   always_ff @(posedge h_clk or negedge h_rstn) begin
      if (!h_rstn) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         sr_q      <= '0;
         data_q    <= '0;
         pending_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sr_q      <= sr_d;
         data_q    <= data_d;
         pending_q <= pending_d;
      end
   end

   always_comb begin
      qspi_io_out    = '0;
      qspi_io_oe_out = '0;
      unique case (state_q)
         StCmd: begin
            qspi_io_out    = {3'b000, sr_q[31]};
            qspi_io_oe_out = 4'b0001;
         end
         StAddr, StMode: begin
            qspi_io_out    = sr_q[31:28];
            qspi_io_oe_out = 4'b1111;
         end
         default: ;
      endcase
   end

   assign qspi_busy_out     = (state_q != StIdle);
   assign qspi_cs_n_out     = !run;
   assign qspi_sck_out      = sck;
   assign rd_fifo_wr_en_out = push;
   assign rd_fifo_wdata_out = data_q;

endmodule

// File: tb/tb_qspi_xip_read_engine.sv
// Directed bench for the XIP read engine with a behavioural quad-IO flash responder.
module tb_qspi_xip_read_engine;

   localparam int unsigned SckHalf   = 2;
   localparam int unsigned CsHighCyc = 4;
   localparam int unsigned DummyCyc  = 4;

   logic        h_clk = 1'b0;
   logic        h_rstn;
   logic        start, brk, full;
   logic [23:0] addr;
   logic        busy, wr_en, sck, cs_n;
   logic [31:0] wdata;
   logic [3:0]  io_o, io_oe;
   logic [3:0]  io_i = 4'h0;

   always #5 h_clk = ~h_clk;

   qspi_xip_read_engine #(
      .SCK_HALF   (SckHalf),
      .CS_HIGH_CYC(CsHighCyc),
      .DUMMY_CYC  (DummyCyc)
   ) dut (
      .h_clk               (h_clk),
      .h_rstn              (h_rstn),
      .start_new_xip_seq_in(start),
      .break_seq_in        (brk),
      .xip_addr_in         (addr),
      .qspi_busy_out       (busy),
      .rd_fifo_full_in     (full),
      .rd_fifo_wr_en_out   (wr_en),
      .rd_fifo_wdata_out   (wdata),
      .qspi_sck_out        (sck),
      .qspi_cs_n_out       (cs_n),
      .qspi_io_out         (io_o),
      .qspi_io_oe_out      (io_oe),
      .qspi_io_in          (io_i)
   );

   typedef struct {
      string       name;
      logic [23:0] addr;
      logic [31:0] bytes;  // flash bytes in stream order, first byte in [31:24]
      logic [31:0] word;   // hand-packed expected FIFO word
   } vec_t;

   vec_t        vecs[4];
   logic [7:0]  fbytes[8];
   logic [3:0]  rec_io[64];
   logic [3:0]  rec_oe[64];
   logic [31:0] push_log[64];
   int          rises = 0, falls = 0, n_push = 0;
   logic        sck_q = 1'b0;
   int          n_vec = 0, n_bad = 0;

   function automatic logic [3:0] flash_nib(input int j);
      logic [7:0] b;
      if (j > 15) return 4'h0;
      b = fbytes[j / 2];
      return (j % 2 == 1) ? b[3:0] : b[7:4];
   endfunction

   // Flash responder and bus recorder, sampled mid-cycle.
   always @(negedge h_clk) begin
      if (cs_n) begin
         rises = 0;
         falls = 0;
         io_i  = 4'h0;
      end else begin
         if (sck && !sck_q) begin
            if (rises < 64) begin
               rec_io[rises] = io_o;
               rec_oe[rises] = io_oe;
            end
            rises++;
         end
         if (!sck && sck_q) begin
            falls++;
            if (falls >= 20) io_i = flash_nib(falls - 20);
         end
      end
      if (wr_en) begin
         if (n_push < 64) push_log[n_push] = wdata;
         n_push++;
      end
      sck_q = sck;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge h_clk);
      #1;
   endtask

   task automatic set_bytes(input logic [31:0] w0, input logic [31:0] w1);
      for (int i = 0; i < 4; i++) begin
         fbytes[i]     = w0[31 - 8*i -: 8];
         fbytes[i + 4] = w1[31 - 8*i -: 8];
      end
   endtask

   task automatic start_seq(input string name, input logic [23:0] a);
      start = 1'b1;
      addr  = a;
      cyc();
      start = 1'b0;
      addr  = 24'h0;
      check({name, "_start"}, {30'h0, busy, cs_n}, 32'h2);
   endtask

   task automatic wait_npush(input string name, input int target);
      int t = 0;
      while (n_push < target && t < 600) begin
         cyc();
         t++;
      end
      check({name, "_push_seen"}, 32'(n_push >= target), 32'h1);
   endtask

   task automatic wait_rises(input string name, input int target);
      int t = 0;
      while (rises < target && t < 600) begin
         cyc();
         t++;
      end
      check({name, "_sck_progress"}, 32'(rises >= target), 32'h1);
   endtask

   task automatic do_break(input string name);
      int t    = 0;
      int hold = 0;
      logic bad = 1'b0;
      brk = 1'b1;
      while (!cs_n && t < 50) begin
         cyc();
         t++;
      end
      brk = 1'b0;
      check({name, "_cs_rise"}, {31'h0, cs_n}, 32'h1);
      while (busy && hold < 50) begin
         if (sck || !cs_n) bad = 1'b1;
         hold++;
         cyc();
      end
      check({name, "_cs_hold_cycles"}, 32'(hold), 32'(CsHighCyc));
      check({name, "_hold_bus_quiet"}, {31'h0, bad}, 32'h0);
   endtask

   task automatic check_frames(input string name, input logic [23:0] a);
      logic [7:0]  cmd = '0;
      logic [23:0] ad  = '0;
      for (int i = 0; i < 8; i++) cmd = {cmd[6:0], rec_io[i][0]};
      for (int i = 8; i < 14; i++) ad = {ad[19:0], rec_io[i]};
      check({name, "_cmd"}, {24'h0, cmd}, 32'hEB);
      check({name, "_addr"}, {8'h0, ad}, {8'h0, a});
      check({name, "_mode"}, {24'h0, rec_io[14], rec_io[15]}, 32'hA0);
      check({name, "_oe"}, {8'h0, rec_oe[7], rec_oe[8], rec_oe[15], rec_oe[16], rec_oe[19],
                            rec_oe[20]}, 32'h001F_F000);
   endtask

   task automatic run_vec(input vec_t v);
      int base = n_push;
      set_bytes(v.bytes, 32'h5566_7788);
      start_seq(v.name, v.addr);
      wait_npush(v.name, base + 1);
      do_break(v.name);
      check_frames(v.name, v.addr);
      check({v.name, "_word"}, push_log[base], v.word);
      check({v.name, "_push_count"}, 32'(n_push - base), 32'h1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   base;
      int   t;
      int   low_cyc;
      logic bad;

      vecs[0] = '{"basic",  24'h001234, 32'h1122_3344, 32'h4433_2211};
      vecs[1] = '{"abcdef", 24'hABCDEF, 32'hDEAD_BEEF, 32'hEFBE_ADDE};
      vecs[2] = '{"top",    24'hFFFFFF, 32'h00FF_5AA5, 32'hA55A_FF00};
      vecs[3] = '{"zero",   24'h000000, 32'h0123_4567, 32'h6745_2301};

      h_rstn = 1'b0;
      start  = 1'b0;
      brk    = 1'b0;
      full   = 1'b0;
      addr   = 24'h0;
      set_bytes(32'h0, 32'h0);
      #1;
      check("reset_outputs", {busy, cs_n, sck, wr_en, io_oe, io_o, 20'h0},
            {1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 20'h0});
      check("reset_wdata", wdata, 32'h0);
      cyc();
      cyc();
      h_rstn = 1'b1;
      cyc();

      for (int i = 0; i < 4; i++) run_vec(vecs[i]);

      // FIFO full at the first word: SCK parks low, push lands when full drops.
      set_bytes(32'h1122_3344, 32'h5566_7788);
      full = 1'b1;
      base = n_push;
      start_seq("stall", 24'h000040);
      t = 0;
      while (!(rises >= 28 && !sck) && t < 600) begin
         cyc();
         t++;
      end
      check("stall_reached", 32'(rises), 32'd28);
      bad = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (sck || wr_en) bad = 1'b1;
         cyc();
      end
      check("stall_sck_low", {31'h0, bad}, 32'h0);
      check("stall_no_rise", 32'(rises), 32'd28);
      full = 1'b0;
      #1;
      check("stall_push_now", {31'h0, wr_en}, 32'h1);
      check("stall_push_data", wdata, 32'h4433_2211);
      wait_npush("stall_second", base + 2);
      check("stall_second_word", push_log[base + 1], 32'h8877_6655);
      do_break("stall");
      check("stall_push_count", 32'(n_push - base), 32'd2);

      // Break during the address phase discards everything; a new start still works.
      base = n_push;
      start_seq("brk_addr", 24'h123456);
      wait_rises("brk_addr", 10);
      do_break("brk_addr");
      check("brk_addr_no_push", 32'(n_push - base), 32'h0);
      check("brk_addr_idle", {30'h0, busy, sck}, 32'h0);
      run_vec(vecs[1]);

      // Break raised in the very cycle the push strobe is high.
      set_bytes(32'hCAFE_F00D, 32'h5566_7788);
      base = n_push;
      start_seq("brk_push", 24'h00BEEF);
      t = 0;
      while (!wr_en && t < 600) begin
         cyc();
         t++;
      end
      check("brk_push_strobe", {30'h0, wr_en, cs_n}, 32'h2);
      do_break("brk_push");
      check("brk_push_count", 32'(n_push - base), 32'h1);
      check("brk_push_word", push_log[base], 32'h0DF0_FECA);

      // Asynchronous reset in the middle of the data phase.
      set_bytes(32'h1122_3344, 32'h5566_7788);
      start_seq("rst_data", 24'h000100);
      wait_rises("rst_data", 24);
      h_rstn = 1'b0;
      #1;
      check("rst_data_outputs", {busy, cs_n, sck, wr_en, io_oe, io_o, 20'h0},
            {1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 20'h0});
      check("rst_data_wdata", wdata, 32'h0);
      cyc();
      h_rstn = 1'b1;
      cyc();
      check("rst_data_idle", {30'h0, busy, cs_n}, 32'h1);

      // Start pulses while busy are ignored.
      set_bytes(32'h9988_7766, 32'h5566_7788);
      base = n_push;
      start_seq("busy_start", 24'h0A0B0C);
      wait_rises("busy_start", 4);
      start = 1'b1;
      addr  = 24'hFFFFFF;
      cyc();
      start = 1'b0;
      addr  = 24'h0;
      wait_npush("busy_start", base + 1);
      do_break("busy_start");
      check_frames("busy_start", 24'h0A0B0C);
      check("busy_start_word", push_log[base], 32'h6677_8899);
      check("busy_start_count", 32'(n_push - base), 32'h1);
      low_cyc = 0;
      for (int i = 0; i < 40; i++) begin
         if (!cs_n || busy) low_cyc++;
         cyc();
      end
      check("busy_start_no_second_cmd", 32'(low_cyc), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/qspi_xip_read_engine.md
QSPI_XIP_READ_ENGINE -- requirements
Module: qspi_xip_read_engine

Interface
REQ-001 SHALL have parameter SCK_HALF, default 2, meaning the number of h_clk cycles per SCK half-period (legal values 1 to 15).
REQ-002 SHALL have parameter CS_HIGH_CYC, default 4, meaning the minimum number of h_clk cycles qspi_cs_n is held high between sequences.
REQ-003 SHALL have parameter DUMMY_CYC, default 4, meaning the number of SCK dummy cycles after the mode byte.
REQ-004 SHALL have ports (name, direction, width, meaning):
- h_clk, in, 1, the single clock.
- h_rstn, in, 1, asynchronous active-low reset.
- start_new_xip_seq_in, in, 1, pulse that starts a sequence.
- break_seq_in, in, 1, level request to end the sequence.
- xip_addr_in, in, 24, flash byte address; sampled on start.
- qspi_busy_out, out, 1, engine active.
- rd_fifo_full_in, in, 1, read FIFO full.
- rd_fifo_wr_en_out, out, 1, one-cycle push strobe.
- rd_fifo_wdata_out, out, 32, pushed word.
- qspi_sck_out, out, 1, flash clock.
- qspi_cs_n_out, out, 1, flash chip select.
- qspi_io_out, out, 4, IO drive value.
- qspi_io_oe_out, out, 4, IO drive enables.
- qspi_io_in, in, 4, IO sampled values.
REQ-005 SHALL run on one clock, h_clk, with asynchronous active-low reset h_rstn.

Function
REQ-006 SHALL use states IDLE, CMD, ADDR, MODE, DUMMY, DATA and CS_HOLD.
REQ-007 SHALL, in IDLE, accept start_new_xip_seq_in by capturing xip_addr_in, setting qspi_busy_out high on the next cycle, asserting qspi_cs_n_out low and entering CMD.
REQ-008 SHALL ignore start_new_xip_seq_in in every state other than IDLE.
REQ-009 SHALL use SPI mode 0: SCK idles low, outputs change with the SCK falling edge (or on CS assertion for the first bit), and inputs are sampled in the h_clk cycle that drives SCK high.
REQ-010 SHALL, in CMD, shift out 0xEB MSB-first on IO0 over 8 SCK cycles, with io_oe=4'b0001.
REQ-011 SHALL, in ADDR, shift out addr[23:0] as 6 nibbles, high nibble first, with io_oe=4'b1111.
REQ-012 SHALL, in MODE, drive 0xA0 as 2 nibbles with io_oe=4'b1111.
REQ-013 SHALL, in DUMMY, issue DUMMY_CYC SCK cycles with io_oe=4'b0000.
REQ-014 SHALL, in DATA, sample one nibble per SCK cycle, high nibble of each byte first, and pack the first byte received into wdata[7:0], up to the fourth into [31:24].
REQ-015 SHALL push the word with rd_fifo_wr_en_out for exactly one cycle after the 8th nibble, only when rd_fifo_full_in=0.
REQ-016 SHALL, while a completed word is unpushed, hold SCK low and issue no further rising edges; the pending push completes in the first cycle that rd_fifo_full_in=0.
REQ-017 SHALL continue DATA indefinitely; the address is implicit in the flash and no internal address counter is kept.
REQ-018 SHALL, on break_seq_in in any non-IDLE, non-CS_HOLD state, complete the current SCK high phase, drive SCK low, raise qspi_cs_n_out and enter CS_HOLD.
REQ-019 SHALL discard any partial word or pending word on break; no push occurs after the break is taken.
REQ-020 SHALL, when a break and a push arrive in the same cycle, let the push occur and then take the break.
REQ-021 SHALL remain in CS_HOLD for CS_HIGH_CYC cycles, then enter IDLE and drop qspi_busy_out.
REQ-022 SHALL hold qspi_busy_out high in every state except IDLE.

Reset
REQ-023 SHALL, on h_rstn low, immediately go to IDLE with qspi_cs_n_out=1, qspi_sck_out=0, io_oe=0, io_out=0, rd_fifo_wr_en_out=0, rd_fifo_wdata_out=0 and qspi_busy_out=0.
REQ-024 SHALL treat reset mid-sequence the same as REQ-023, with no CS_HOLD and all counters cleared.

Structure
REQ-025 SHALL place the state enum, the 0xEB command constant and the 0xA0 mode constant in the shared package qspi_pkg.
REQ-026 SHALL implement the SCK divider and edge strobes in one sub-module, qspi_sck_gen, with inputs run and stall and outputs sck, rise_stb and fall_stb.

Verification
REQ-027 SHALL cover a basic read: addr=0x001234, flash model returning bytes 0x11,0x22,0x33,0x44, then break -> IO0 carries 0xEB, IO carries nibbles 0,0,1,2,3,4 then A,0, exactly 4 dummy SCKs, one push of 0x44332211.
REQ-028 SHALL cover stall: rd_fifo_full_in held high for 20 cycles at the first word -> SCK stays low, the push occurs in the first cycle after full drops, the next data bytes are uncorrupted.
REQ-029 SHALL cover break during ADDR -> CS high with no push, CS high for 4 cycles, busy low afterwards, and a new start accepted.
REQ-030 SHALL cover break in the same cycle as a push -> the push occurs, then CS rises.
REQ-031 SHALL cover reset during DATA -> all outputs are at reset values in the same cycle.
REQ-032 SHALL cover a start pulse while busy -> ignored, with no second command issued.
